// File: rtl/reset_sequencer_if.sv
// Board reset sequencer signal bundle: lock/request inputs and the sequenced reset outputs.
interface reset_sequencer_if;
    logic       pll_lock;
    logic       nios_reset_req;
    logic       sw_isl_reset_req;
    logic       sw_tx_reset_req;
    logic       sys_reset_n;
    logic       isl_reset_n;
    logic       hdmitx_reset_n;
    logic       seq_done;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_lock, nios_reset_req, sw_isl_reset_req, sw_tx_reset_req,
        input  sys_reset_n, isl_reset_n, hdmitx_reset_n, seq_done, seq_state, lock_loss_cnt
    );

    modport slave (
        input  pll_lock, nios_reset_req, sw_isl_reset_req, sw_tx_reset_req,
        output sys_reset_n, isl_reset_n, hdmitx_reset_n, seq_done, seq_state, lock_loss_cnt
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / recovery reset sequencer: waits for a filtered PLL lock, then releases
// sys, ISL and HDMI TX resets in order with programmable hold times.
module reset_sequencer #(
    parameter int unsigned LOCK_FILT_CYCLES = 2700,
    parameter int unsigned SYS_RST_CYCLES   = 2700,
    parameter int unsigned ISL_RST_CYCLES   = 270000,
    parameter int unsigned TX_RST_CYCLES    = 270000,
    parameter int unsigned SETTLE_CYCLES    = 27000,
    parameter int unsigned CNT_W            = 20
) (
    input  logic             clk27,
    input  logic             reset,
    reset_sequencer_if.slave bus
);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_SYS_RST   = 3'd1;
    localparam logic [2:0] S_ISL_RST   = 3'd2;
    localparam logic [2:0] S_TX_RST    = 3'd3;
    localparam logic [2:0] S_SETTLE    = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;

    localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(LOCK_FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYS_LAST    = CNT_W'(SYS_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ISL_LAST    = CNT_W'(ISL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(TX_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] filt_q, filt_d;
    logic [7:0]       llc_q, llc_d;
    logic             sys_n_q, sys_n_d;
    logic             isl_n_q, isl_n_d;
    logic             tx_n_q, tx_n_d;
    logic             done_q, done_d;

    logic lock_s;
    logic lock_lost;
    logic nios_hit;

    assign sync_d    = {sync_q[0], bus.pll_lock};
    assign lock_s    = sync_q[1];
    assign lock_lost = (state_q >= S_SYS_RST) && (state_q <= S_RUN) && !lock_s;
    assign nios_hit  = (state_q >= S_ISL_RST) && (state_q <= S_RUN) && bus.nios_reset_req;

    // Next state: lock loss beats a Nios restart, which beats normal sequencing.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        filt_d  = '0;
        llc_d   = llc_q;
        if (lock_lost) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
            if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end else if (nios_hit) begin
            state_d = S_SYS_RST;
            timer_d = SYS_LAST;
        end else begin
            case (state_q)
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        if (filt_q == FILT_LAST) begin
                            state_d = S_SYS_RST;
                            timer_d = SYS_LAST;
                        end else begin
                            filt_d = filt_q + CNT_W'(1);
                        end
                    end
                end
                S_SYS_RST: begin
                    if (timer_q == '0) begin
                        state_d = S_ISL_RST;
                        timer_d = ISL_LAST;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_ISL_RST: begin
                    if (timer_q == '0) begin
                        state_d = S_TX_RST;
                        timer_d = TX_LAST;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_TX_RST: begin
                    if (timer_q == '0) begin
                        state_d = S_SETTLE;
                        timer_d = SETTLE_LAST;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (timer_q == '0) begin
                        state_d = S_RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs follow the state being entered; sw requests only act when already running.
    always_comb begin
        sys_n_d = 1'b0;
        isl_n_d = 1'b0;
        tx_n_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_ISL_RST: sys_n_d = 1'b1;
            S_TX_RST: begin
                sys_n_d = 1'b1;
                isl_n_d = 1'b1;
            end
            S_SETTLE: begin
                sys_n_d = 1'b1;
                isl_n_d = 1'b1;
                tx_n_d  = 1'b1;
            end
            S_RUN: begin
                sys_n_d = 1'b1;
                isl_n_d = !(bus.sw_isl_reset_req && (state_q == S_RUN));
                tx_n_d  = !(bus.sw_tx_reset_req && (state_q == S_RUN));
                done_d  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk27 or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= S_WAIT_LOCK;
            timer_q <= '0;
            filt_q  <= '0;
            llc_q   <= '0;
            sys_n_q <= 1'b0;
            isl_n_q <= 1'b0;
            tx_n_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            timer_q <= timer_d;
            filt_q  <= filt_d;
            llc_q   <= llc_d;
            sys_n_q <= sys_n_d;
            isl_n_q <= isl_n_d;
            tx_n_q  <= tx_n_d;
            done_q  <= done_d;
        end
    end

    assign bus.sys_reset_n    = sys_n_q;
    assign bus.isl_reset_n    = isl_n_q;
    assign bus.hdmitx_reset_n = tx_n_q;
    assign bus.seq_done       = done_q;
    assign bus.seq_state      = state_q;
    assign bus.lock_loss_cnt  = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus randomized
// lock/request traffic compared against a phase-based reference model.
module tb_reset_sequencer;

    localparam int FILT    = 4;
    localparam int SYS     = 4;
    localparam int ISL     = 8;
    localparam int TX      = 6;
    localparam int SET     = 3;
    localparam int SEQ_LAT = 2 + FILT + SYS + ISL + TX + SET;

    logic clk27 = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   exp_llc = 0;

    always #5 clk27 = ~clk27;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .LOCK_FILT_CYCLES(FILT),
        .SYS_RST_CYCLES  (SYS),
        .ISL_RST_CYCLES  (ISL),
        .TX_RST_CYCLES   (TX),
        .SETTLE_CYCLES   (SET),
        .CNT_W           (20)
    ) dut (
        .clk27(clk27),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model: phase index plus time spent in phase, outputs derived from
    // how many resets the phase has released.
    bit m_s1 = 1'b0, m_s2 = 1'b0, m_lk = 1'b0;
    int m_state = 0, m_prev = 0, m_elapsed = 0, m_filt = 0, m_llc = 0;
    bit m_sys = 1'b0, m_isl = 1'b0, m_tx = 1'b0, m_done = 1'b0;

    function automatic int dur_of(input int s);
        case (s)
            1: return SYS;
            2: return ISL;
            3: return TX;
            default: return SET;
        endcase
    endfunction

    always @(posedge clk27 or posedge reset) begin
        if (reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_state = 0; m_elapsed = 0; m_filt = 0; m_llc = 0;
            m_sys = 1'b0; m_isl = 1'b0; m_tx = 1'b0; m_done = 1'b0;
        end else begin
            m_prev = m_state;
            m_lk   = m_s2;
            if (m_state >= 1 && !m_lk) begin
                m_state = 0; m_elapsed = 0; m_filt = 0;
                if (m_llc < 255) m_llc++;
            end else if (m_state >= 2 && bus.nios_reset_req) begin
                m_state = 1; m_elapsed = 0;
            end else if (m_state == 0) begin
                if (m_lk) begin
                    m_filt++;
                    if (m_filt == FILT) begin m_state = 1; m_elapsed = 0; m_filt = 0; end
                end else m_filt = 0;
            end else if (m_state <= 4) begin
                m_elapsed++;
                if (m_elapsed == dur_of(m_state)) begin m_state++; m_elapsed = 0; end
            end
            m_s2 = m_s1;
            m_s1 = bus.pll_lock;
            m_sys  = (m_state >= 2);
            m_isl  = (m_state >= 3);
            m_tx   = (m_state >= 4);
            m_done = (m_state == 5);
            if (m_state == 5) begin
                m_isl = !(m_prev == 5 && bus.sw_isl_reset_req);
                m_tx  = !(m_prev == 5 && bus.sw_tx_reset_req);
            end
        end
    end

    task automatic tick();
        @(posedge clk27);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.pll_lock = 1'b0; bus.nios_reset_req = 1'b0;
        bus.sw_isl_reset_req = 1'b0; bus.sw_tx_reset_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        exp_llc = 0;
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (bus.seq_state !== 3'(s) && n < budget) begin tick(); n++; end
        checks++;
        if (bus.seq_state !== 3'(s)) begin
            errors++;
            $display("FAIL wait_state: seq_state=%0d, required %0d within %0d edges", bus.seq_state, s, budget);
        end
    endtask

    task automatic edges_to_done(output int n);
        n = -1;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (bus.seq_done === 1'b1) begin n = e; break; end
        end
    endtask

    task automatic test_reset();
        logic [14:0] got;
        reset = 1'b1;
        bus.pll_lock = 1'b0; bus.nios_reset_req = 1'b0;
        bus.sw_isl_reset_req = 1'b0; bus.sw_tx_reset_req = 1'b0;
        tick(); tick();
        got = {bus.seq_state, bus.sys_reset_n, bus.isl_reset_n, bus.hdmitx_reset_n, bus.seq_done, bus.lock_loss_cnt};
        checks++;
        if (got !== 15'h0) begin errors++; $display("FAIL reset_values: got %h, required 0", got); end
        reset = 1'b0;
        tick(); tick();
        got = {bus.seq_state, bus.sys_reset_n, bus.isl_reset_n, bus.hdmitx_reset_n, bus.seq_done, bus.lock_loss_cnt};
        checks++;
        if (got !== 15'h0) begin errors++; $display("FAIL idle_no_lock: got %h, required 0", got); end
        exp_llc = 0;
    endtask

    task automatic test_power_on();
        int t_done, t_isl, t_tx, walk, exp_walk;
        logic [2:0] last;
        t_done = -1; t_isl = -1; t_tx = -1;
        last = bus.seq_state;
        walk = int'(last);
        exp_walk = 0;
        for (int s = 0; s <= 5; s++) exp_walk = exp_walk * 8 + s;
        bus.pll_lock = 1'b1;
        for (int e = 1; e <= 40 && t_done < 0; e++) begin
            tick();
            if (bus.seq_state !== last) begin last = bus.seq_state; walk = walk * 8 + int'(last); end
            if (t_isl < 0 && bus.isl_reset_n === 1'b1) t_isl = e;
            if (t_tx < 0 && bus.hdmitx_reset_n === 1'b1) t_tx = e;
            if (bus.seq_done === 1'b1) t_done = e;
        end
        checks++;
        if (t_done != SEQ_LAT) begin errors++; $display("FAIL power_on_done_edge: %0d, required %0d", t_done, SEQ_LAT); end
        checks++;
        if (t_isl != 2 + FILT + SYS + ISL) begin errors++; $display("FAIL power_on_isl_edge: %0d, required %0d", t_isl, 2 + FILT + SYS + ISL); end
        checks++;
        if (t_tx != 2 + FILT + SYS + ISL + TX) begin errors++; $display("FAIL power_on_tx_edge: %0d, required %0d", t_tx, 2 + FILT + SYS + ISL + TX); end
        checks++;
        if (walk != exp_walk) begin errors++; $display("FAIL power_on_walk: %o, required %o", walk, exp_walk); end
    endtask

    task automatic test_async_reset();
        logic [14:0] got;
        int n;
        bus.nios_reset_req = 1'b1; tick(); bus.nios_reset_req = 1'b0;
        wait_state(2, 20);
        #2 reset = 1'b1;
        #1;
        got = {bus.seq_state, bus.sys_reset_n, bus.isl_reset_n, bus.hdmitx_reset_n, bus.seq_done, bus.lock_loss_cnt};
        checks++;
        if (got !== 15'h0) begin errors++; $display("FAIL async_reset_immediate: got %h, required 0", got); end
        tick(); tick();
        reset = 1'b0;
        exp_llc = 0;
        edges_to_done(n);
        checks++;
        if (n != SEQ_LAT) begin errors++; $display("FAIL async_reset_restart: done at %0d, required %0d", n, SEQ_LAT); end
    endtask

    task automatic test_glitch();
        int n;
        apply_reset();
        bus.pll_lock = 1'b1; repeat (3) tick();
        bus.pll_lock = 1'b0; tick();
        bus.pll_lock = 1'b1;
        n = -1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (bus.seq_state !== 3'd0) begin n = e; break; end
        end
        checks++;
        if (n != 2 + FILT) begin errors++; $display("FAIL glitch_filter_restart: left WAIT_LOCK at %0d, required %0d", n, 2 + FILT); end
        checks++;
        if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL glitch_llc: %0d, required 0", bus.lock_loss_cnt); end
    endtask

    task automatic test_lock_loss();
        logic [14:0] got, exp;
        int n;
        wait_state(5, 40);
        bus.pll_lock = 1'b0;
        tick(); tick();
        checks++;
        if (bus.seq_state !== 3'd5 || bus.seq_done !== 1'b1) begin
            errors++; $display("FAIL lock_loss_early: state=%0d done=%b, required 5/1", bus.seq_state, bus.seq_done);
        end
        tick();
        exp_llc++;
        got = {bus.seq_state, bus.sys_reset_n, bus.isl_reset_n, bus.hdmitx_reset_n, bus.seq_done, bus.lock_loss_cnt};
        exp = {3'd0, 4'b0000, 8'(exp_llc)};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL lock_loss_3_edges: got %h, required %h", got, exp); end
        bus.pll_lock = 1'b1;
        edges_to_done(n);
        checks++;
        if (n != SEQ_LAT) begin errors++; $display("FAIL relock_latency: %0d, required %0d", n, SEQ_LAT); end
    endtask

    task automatic test_nios();
        int t_done, t_isl;
        bus.pll_lock = 1'b0; repeat (4) tick();
        exp_llc++;
        bus.pll_lock = 1'b1;
        wait_state(3, 60);
        bus.nios_reset_req = 1'b1; tick();
        checks++;
        if (bus.seq_state !== 3'd1 || bus.sys_reset_n !== 1'b0) begin
            errors++; $display("FAIL nios_restart: state=%0d sys_n=%b, required 1/0", bus.seq_state, bus.sys_reset_n);
        end
        t_done = -1; t_isl = -1;
        for (int e = 2; e <= 40 && t_done < 0; e++) begin
            tick();
            bus.nios_reset_req = 1'b0;
            if (t_isl < 0 && bus.isl_reset_n === 1'b1) t_isl = e;
            if (bus.seq_done === 1'b1) t_done = e;
        end
        checks++;
        if (t_isl != 1 + SYS + ISL) begin errors++; $display("FAIL nios_isl_edge: %0d, required %0d", t_isl, 1 + SYS + ISL); end
        checks++;
        if (t_done != 1 + SYS + ISL + TX + SET) begin errors++; $display("FAIL nios_done_edge: %0d, required %0d", t_done, 1 + SYS + ISL + TX + SET); end
    endtask

    task automatic test_sw();
        bus.sw_isl_reset_req = 1'b1; tick();
        checks++;
        if (bus.isl_reset_n !== 1'b0 || bus.seq_done !== 1'b1 || bus.hdmitx_reset_n !== 1'b1 || bus.seq_state !== 3'd5) begin
            errors++; $display("FAIL sw_isl_run: isl_n=%b done=%b tx_n=%b state=%0d, required 0/1/1/5",
                                bus.isl_reset_n, bus.seq_done, bus.hdmitx_reset_n, bus.seq_state);
        end
        bus.sw_isl_reset_req = 1'b0; bus.sw_tx_reset_req = 1'b1; tick();
        checks++;
        if (bus.isl_reset_n !== 1'b1 || bus.hdmitx_reset_n !== 1'b0 || bus.seq_done !== 1'b1) begin
            errors++; $display("FAIL sw_tx_run: isl_n=%b tx_n=%b done=%b, required 1/0/1", bus.isl_reset_n, bus.hdmitx_reset_n, bus.seq_done);
        end
        bus.sw_tx_reset_req = 1'b0; tick();
        checks++;
        if (bus.hdmitx_reset_n !== 1'b1) begin errors++; $display("FAIL sw_tx_release: tx_n=%b, required 1", bus.hdmitx_reset_n); end
        bus.nios_reset_req = 1'b1; tick(); bus.nios_reset_req = 1'b0;
        wait_state(4, 40);
        bus.sw_isl_reset_req = 1'b1; tick();
        checks++;
        if (bus.seq_state !== 3'd4 || bus.isl_reset_n !== 1'b1) begin
            errors++; $display("FAIL sw_in_settle: state=%0d isl_n=%b, required 4/1", bus.seq_state, bus.isl_reset_n);
        end
        bus.sw_isl_reset_req = 1'b0;
        wait_state(5, 10);
        checks++;
        if (bus.isl_reset_n !== 1'b1 || bus.seq_done !== 1'b1) begin
            errors++; $display("FAIL sw_not_latched: isl_n=%b done=%b, required 1/1", bus.isl_reset_n, bus.seq_done);
        end
    endtask

    task automatic test_priority();
        bus.pll_lock = 1'b0;
        tick(); tick();
        bus.nios_reset_req = 1'b1; tick(); bus.nios_reset_req = 1'b0;
        exp_llc++;
        checks++;
        if (bus.seq_state !== 3'd0 || bus.lock_loss_cnt !== 8'(exp_llc)) begin
            errors++; $display("FAIL priority_loss_vs_nios: state=%0d llc=%0d, required 0/%0d", bus.seq_state, bus.lock_loss_cnt, exp_llc);
        end
        tick();
        checks++;
        if (bus.lock_loss_cnt !== 8'(exp_llc)) begin errors++; $display("FAIL priority_single_inc: llc=%0d, required %0d", bus.lock_loss_cnt, exp_llc); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            bus.pll_lock = 1'b1;
            wait_state(1, 20);
            bus.pll_lock = 1'b0;
            repeat (3) tick();
            if (exp_llc < 255) exp_llc++;
            if (i == 100) begin
                checks++;
                if (bus.lock_loss_cnt !== 8'(exp_llc)) begin errors++; $display("FAIL llc_count: %0d, required %0d", bus.lock_loss_cnt, exp_llc); end
            end
        end
        checks++;
        if (bus.lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL llc_saturate: %0d, required 255", bus.lock_loss_cnt); end
    endtask

    task automatic test_random();
        logic [14:0] got, exp;
        int hold, rerr;
        apply_reset();
        hold = 0; rerr = 0;
        for (int c = 0; c < 3000 && rerr < 20; c++) begin
            if (hold == 0) begin
                bus.pll_lock = ($urandom_range(0, 99) < 85);
                hold = $urandom_range(1, 80);
            end else hold--;
            bus.nios_reset_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) bus.sw_isl_reset_req = ~bus.sw_isl_reset_req;
            if ($urandom_range(0, 7) == 0) bus.sw_tx_reset_req = ~bus.sw_tx_reset_req;
            tick();
            got = {bus.seq_state, bus.sys_reset_n, bus.isl_reset_n, bus.hdmitx_reset_n, bus.seq_done, bus.lock_loss_cnt};
            exp = {3'(m_state), m_sys, m_isl, m_tx, m_done, 8'(m_llc)};
            checks++;
            if (got !== exp) begin
                errors++; rerr++;
                $display("FAIL random_cycle%0d: got %h, required %h", c, got, exp);
            end
        end
        bus.nios_reset_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.pll_lock = 1'b0; bus.nios_reset_req = 1'b0;
        bus.sw_isl_reset_req = 1'b0; bus.sw_tx_reset_req = 1'b0;
        test_reset();
        test_power_on();
        test_async_reset();
        test_glitch();
        test_lock_loss();
        test_nios();
        test_sw();
        test_priority();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-on and recovery reset sequencer for the vd_isl board top level, running in the `clk27` domain. It waits for the system PLL to hold lock and then releases the resets in order: system (Nios/sys), ISL51002 digitizer, HDMI transmitter. Each release is followed by a programmable hold time. The block re-runs the sequence on PLL lock loss or on a Nios reset request, and applies software-requested ISL/HDMI TX resets once the sequence has finished.

## Interface
Parameters:
- `LOCK_FILT_CYCLES`, default 2700: consecutive synchronized-lock cycles required before sequencing starts (100 µs).
- `SYS_RST_CYCLES`, default 2700: time in `S_SYS_RST`.
- `ISL_RST_CYCLES`, default 270000: time `isl_reset_n` is held low (10 ms).
- `TX_RST_CYCLES`, default 270000: time `hdmitx_reset_n` is held low.
- `SETTLE_CYCLES`, default 27000: settle time before `seq_done`.
- `CNT_W`, default 20: timer width; must hold max(all cycle params) − 1.

Ports:
- `clk27`, input, 1: 27 MHz system clock.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `pll_lock`, input, 1: asynchronous PLL lock; 2-FF synchronized internally.
- `nios_reset_req`, input, 1: single-cycle pulse, synchronous to `clk27`.
- `sw_isl_reset_req`, input, 1: level from sys_ctrl.
- `sw_tx_reset_req`, input, 1: level from sys_ctrl.
- `sys_reset_n`, output, 1: system reset, active-low.
- `isl_reset_n`, output, 1: ISL51002 reset, active-low.
- `hdmitx_reset_n`, output, 1: HDMI TX reset, active-low.
- `seq_done`, output, 1: high only in `S_RUN`.
- `seq_state`, output, 3: current state encoding.
- `lock_loss_cnt`, output, 8: saturating count of lock-loss events.

## Operation
- State encoding: 0 `S_WAIT_LOCK`, 1 `S_SYS_RST`, 2 `S_ISL_RST`, 3 `S_TX_RST`, 4 `S_SETTLE`, 5 `S_RUN`. Codes 6 and 7 go to `S_WAIT_LOCK`.
- `lock_s` is the 2-FF synchronized `pll_lock`. All FSM decisions use `lock_s`.
- `S_WAIT_LOCK`:
  - Filter counter increments while `lock_s` = 1 and clears while `lock_s` = 0.
  - On the edge where `LOCK_FILT_CYCLES` consecutive high cycles are reached, go to `S_SYS_RST`.
- Timed states 1–4:
  - Timer loads N−1 on entry and decrements each cycle. The state exits on the edge where the timer = 0, so the state lasts exactly N cycles.
  - Sequence is 1→2→3→4→5.
- Output values per state (sys/isl/tx `_n`):
  - WAIT_LOCK: 0/0/0.
  - SYS_RST: 0/0/0.
  - ISL_RST: 1/0/0.
  - TX_RST: 1/1/0.
  - SETTLE: 1/1/1.
  - RUN: 1 / ~`sw_isl_reset_req` / ~`sw_tx_reset_req`.
- Event priority, evaluated every cycle:
  1. `lock_s` = 0 in states 1–5 → go to `S_WAIT_LOCK`; `lock_loss_cnt` +1, saturating at 255.
  2. `nios_reset_req` in states 2–5 → go to `S_SYS_RST` with the timer reloaded. A request in states 0 or 1 is ignored.
  3. Software requests have effect only in `S_RUN`. Outside `S_RUN` they are ignored and not latched.
- Simultaneous lock loss and `nios_reset_req`: lock loss wins and the counter increments once.
- The `sw_*` requests do not change state and do not clear `seq_done`.

## Timing
- All outputs are registered. On the edge that enters a state, the outputs take that state's values; there is no extra cycle of lag.
- Values during and after `reset`:
  - `seq_state` = 0.
  - All `_n` outputs = 0.
  - `seq_done` = 0.
  - `lock_loss_cnt` = 0.
  - Timer, filter and synchronizer = 0.
- A `reset` asserted mid-sequence takes effect immediately (asynchronously). After release, the sequence restarts from `S_WAIT_LOCK`.
- Latency from `pll_lock` rising to `seq_done` rising: 2 + `LOCK_FILT_CYCLES` + `SYS_RST_CYCLES` + `ISL_RST_CYCLES` + `TX_RST_CYCLES` + `SETTLE_CYCLES` edges.
- Latency from `pll_lock` falling to all resets asserted: 3 edges (2 sync + 1 FSM).
- `sw_*` request to output change: 1 edge while in `S_RUN`.

## Test plan
Parameters for all scenarios: FILT=4, SYS=4, ISL=8, TX=6, SETTLE=3.

- **Power-on.** Raise `pll_lock` and hold it.
  - `seq_done` rises exactly 27 edges later.
  - `isl_reset_n` rises at edge 18 and `hdmitx_reset_n` at edge 24.
  - `seq_state` walks through 0,1,2,3,4,5.
- **Lock glitch before lock is accepted.** `pll_lock` high 3 cycles, low 1, then high.
  - The filter restarts; `S_SYS_RST` is entered only after 4 new consecutive high cycles.
  - `lock_loss_cnt` stays 0.
- **Lock loss in `S_RUN`.** Drop `pll_lock`.
  - 3 edges later: all `_n` = 0, `seq_done` = 0, `seq_state` = 0, `lock_loss_cnt` = 1.
  - Re-lock reproduces the 27-edge sequence.
- **`nios_reset_req` in `S_TX_RST`.**
  - Next edge: `seq_state` = 1 and `sys_reset_n` = 0.
  - The full timed sequence then replays.
- **Software requests.**
  - `sw_isl_reset_req` = 1 in `S_RUN` → `isl_reset_n` = 0 one edge later, with `seq_done` staying 1.
  - The same request asserted during `S_SETTLE` has no effect.
- **Saturation and priority.**
  - 260 lock losses → `lock_loss_cnt` = 255.
  - Lock loss coincident with `nios_reset_req` → `seq_state` = 0 and a single increment.
